// File: rtl/cordic_rr_arbiter.sv
// cordic_rr_arbiter
//   Shares one CORDIC core between N_REQ requesters with round-robin
//   arbitration. Each granted operation is sequenced as:
//   core reset (CLR) -> angle settle (LOAD) -> start pulse (START) ->
//   wait for core valid (WAIT) -> one-cycle tagged response (RESP).
//
// Optional build macro: CORDIC_TIMEOUT_EN
//   Defined   : WAIT is bounded by TIMEOUT_CYCLES; on expiry a response is
//               returned with resp_err=1 and zero sin/cos.
//   Undefined : WAIT waits indefinitely; resp_err is tied low.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   req_valid       per-requester request pending
//   req_angle       per-requester IEEE754 angle, requester i at [32i+31:32i]
//   req_ready       one-hot accept strobe (combinational, IDLE only)
//   resp_valid      one-cycle result strobe
//   resp_id/sin/cos result owner and Q15 sine/cosine (held until next RESP)
//   resp_err        timeout flag, qualified by resp_valid
//   busy            high whenever an operation is in flight
//   cordic_rst      core reset (rst or CLR state)
//   cordic_start    core start pulse
//   cordic_angle    registered angle to the core
//   cordic_sin/cos  core results
//   cordic_valid    core done level
module cordic_rr_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_angle,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic signed [15:0]   resp_sin,
    output logic signed [15:0]   resp_cos,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 cordic_rst,
    output logic                 cordic_start,
    output logic [31:0]          cordic_angle,
    input  logic signed [15:0]   cordic_sin,
    input  logic signed [15:0]   cordic_cos,
    input  logic                 cordic_valid
);

    if (IDW != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("cordic_rr_arbiter: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, CLR, LOAD, START, WAIT, RESP} state_t;

    state_t                  state;
    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          grant;
    logic                    grant_vld;
    // Owner of the in-flight operation; copied to resp_id only when the
    // result is published so resp_id stays stable between responses.
    logic [IDW-1:0]          owner;
    logic [N_REQ-1:0][31:0]  angle_arr;

    assign angle_arr = req_angle;

    // First pending requester at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant     = IDW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld)
            req_ready[grant] = 1'b1;
    end

    assign busy         = (state != IDLE);
    assign resp_valid   = (state == RESP);
    assign cordic_start = (state == START);
    assign cordic_rst   = rst || (state == CLR);

`ifdef CORDIC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            cordic_angle <= '0;
            resp_id      <= '0;
            resp_sin     <= '0;
            resp_cos     <= '0;
`ifdef CORDIC_TIMEOUT_EN
            resp_err     <= 1'b0;
            to_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cordic_angle <= angle_arr[grant];
                        owner        <= grant;
                        ptr          <= (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
                        state        <= CLR;
                    end
                end
                CLR:   state <= LOAD;
                LOAD:  state <= START;
                START: begin
`ifdef CORDIC_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cordic_valid) begin
                        resp_sin <= cordic_sin;
                        resp_cos <= cordic_cos;
                        resp_id  <= owner;
`ifdef CORDIC_TIMEOUT_EN
                        resp_err <= 1'b0;
`endif
                        state    <= RESP;
                    end
`ifdef CORDIC_TIMEOUT_EN
                    // Expires on the TIMEOUT_CYCLES-th WAIT cycle.
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_sin <= '0;
                        resp_cos <= '0;
                        resp_id  <= owner;
                        resp_err <= 1'b1;
                        state    <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter with a latency-16 stub core.
module tb_cordic_rr_arbiter;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [32*N_REQ-1:0] req_angle;
    logic [N_REQ-1:0]   req_ready;
    logic               resp_valid;
    logic [IDW-1:0]     resp_id;
    logic signed [15:0] resp_sin, resp_cos;
    logic               resp_err, busy;
    logic               cordic_rst, cordic_start;
    logic [31:0]        cordic_angle;
    logic signed [15:0] cordic_sin, cordic_cos;
    logic               cordic_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_sin(resp_sin), .resp_cos(resp_cos), .resp_err(resp_err),
        .busy(busy), .cordic_rst(cordic_rst), .cordic_start(cordic_start),
        .cordic_angle(cordic_angle), .cordic_sin(cordic_sin),
        .cordic_cos(cordic_cos), .cordic_valid(cordic_valid)
    );

    // Stub core: ideal Q15 table, valid 16 cycles after the start pulse.
    logic        stub_run;
    logic [4:0]  stub_cnt;
    logic [31:0] stub_ang;
    logic        stub_never;

    function automatic logic [15:0] tab_sin(input logic [31:0] a);
        case (a)
            32'h41F00000: return 16'h4000;
            32'h42340000: return 16'h5A82;
            32'h42B40000: return 16'h7FFF;
            default:      return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] tab_cos(input logic [31:0] a);
        case (a)
            32'h41F00000: return 16'h6EDA;
            32'h42340000: return 16'h5A82;
            32'h42B40000: return 16'h0000;
            default:      return 16'h7FFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (cordic_rst) begin
            stub_run <= 1'b0;
            stub_cnt <= '0;
            stub_ang <= '0;
        end else if (cordic_start) begin
            stub_run <= 1'b1;
            stub_cnt <= 5'd1;
            stub_ang <= cordic_angle;
        end else if (stub_run && stub_cnt != 5'd16) begin
            stub_cnt <= stub_cnt + 5'd1;
        end
    end

    assign cordic_valid = stub_run && (stub_cnt == 5'd16) && !stub_never;
    assign cordic_sin   = tab_sin(stub_ang);
    assign cordic_cos   = tab_cos(stub_ang);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until resp_valid is seen; n = ticks taken, -1 if the bound expired.
    task automatic wait_resp(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (resp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int seen;
        int drop;

        // ---------------- reset state
        rst = 1'b1; req_valid = '0; req_angle = '0; stub_never = 1'b0;
        tick(); tick();
        chk("rst_ready",      32'(req_ready),    32'h0);
        chk("rst_resp_valid", 32'(resp_valid),   32'h0);
        chk("rst_resp_id",    32'(resp_id),      32'h0);
        chk("rst_resp_sin",   32'(resp_sin),     32'h0);
        chk("rst_resp_cos",   32'(resp_cos),     32'h0);
        chk("rst_resp_err",   32'(resp_err),     32'h0);
        chk("rst_busy",       32'(busy),         32'h0);
        chk("rst_start",      32'(cordic_start), 32'h0);
        chk("rst_angle",      cordic_angle,      32'h0);
        chk("rst_cordic_rst", 32'(cordic_rst),   32'h1);
        rst = 1'b0;
        tick();

        // ---------------- T1: requester 0, 0 deg, step-by-step sequencing
        req_valid = 4'b0001; req_angle[31:0] = 32'h00000000;
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        tick();                                    // grant edge -> CLR
        req_valid = '0;
        chk("t1_clr_rst",   32'(cordic_rst), 32'h1);
        chk("t1_clr_busy",  32'(busy),       32'h1);
        chk("t1_clr_ready", 32'(req_ready),  32'h0);
        tick();                                    // LOAD
        chk("t1_load_rst",   32'(cordic_rst),   32'h0);
        chk("t1_load_start", 32'(cordic_start), 32'h0);
        tick();                                    // START
        chk("t1_start", 32'(cordic_start), 32'h1);
        wait_resp(40, n);
        chk("t1_latency", n, 17);
        chk("t1_id",  32'(resp_id),  32'h0);
        chk("t1_sin", 32'(resp_sin), 32'h0000);
        chk("t1_cos", 32'(resp_cos), 32'h7FFF);
        chk("t1_err", 32'(resp_err), 32'h0);
        tick();
        chk("t1_resp_drop", 32'(resp_valid), 32'h0);
        chk("t1_idle_busy", 32'(busy),       32'h0);
        chk("t1_cos_hold",  32'(resp_cos),   32'h7FFF);

        // ---------------- T2: requester 2 only, 45 deg
        req_valid = 4'b0100; req_angle[95:64] = 32'h42340000;
        #1 chk("t2_ready", 32'(req_ready), 32'h4);
        tick(); req_valid = '0;
        tick(); tick();
        chk("t2_start", 32'(cordic_start), 32'h1);
        chk("t2_angle", cordic_angle, 32'h42340000);
        wait_resp(40, n);
        chk("t2_latency", n, 17);
        chk("t2_id",  32'(resp_id),  32'h2);
        chk("t2_sin", 32'(resp_sin), 32'h5A82);
        chk("t2_cos", 32'(resp_cos), 32'h5A82);
        tick();

        // ---------------- T3: all four together, pointer reset to 0
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_angle = {32'h42B40000, 32'h42340000, 32'h41F00000, 32'h00000000};
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t3_ready%0d", k), 32'(req_ready), 32'(1 << k));
            tick();
            req_valid[k] = 1'b0;
            chk($sformatf("t3_ready_busy%0d", k), 32'(req_ready), 32'h0);
            wait_resp(40, n);
            chk($sformatf("t3_lat%0d", k), n, 19);
            chk($sformatf("t3_id%0d", k), 32'(resp_id), 32'(k));
            chk($sformatf("t3_sin%0d", k), 32'(resp_sin), 32'(tab_sin(req_angle[32*k +: 32])));
            chk($sformatf("t3_cos%0d", k), 32'(resp_cos), 32'(tab_cos(req_angle[32*k +: 32])));
            tick();
        end
        chk("t3_sin90", 32'(resp_sin), 32'h7FFF);
        chk("t3_cos90", 32'(resp_cos), 32'h0000);

        // ---------------- T4: pointer at 2, requesters 1 and 3 pending
        req_valid = 4'b0010;                       // moves pointer to 2
        #1 chk("t4_pre_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = '0;
        wait_resp(40, n); tick();
        req_valid = 4'b1010;
        #1 chk("t4_first", 32'(req_ready), 32'h8);
        tick();                                    // requester 3 keeps requesting
        wait_resp(40, n);
        chk("t4_id_a", 32'(resp_id), 32'h3);
        tick();
        #1 chk("t4_second", 32'(req_ready), 32'h2);
        tick(); req_valid = 4'b1000;
        wait_resp(40, n);
        chk("t4_id_b", 32'(resp_id), 32'h1);
        tick();
        #1 chk("t4_third", 32'(req_ready), 32'h8);
        tick(); req_valid = '0;
        wait_resp(40, n);
        chk("t4_id_c", 32'(resp_id), 32'h3);
        tick();

        // ---------------- T5: reset during WAIT
        req_valid = 4'b0001;
        tick(); req_valid = '0;
        tick(); tick(); tick(); tick(); tick();    // inside WAIT
        chk("t5_wait_busy", 32'(busy), 32'h1);
        rst = 1'b1; tick();
        chk("t5_rst_busy",  32'(busy),       32'h0);
        chk("t5_rst_core",  32'(cordic_rst), 32'h1);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        chk("t5_no_resp", seen, 0);
        req_valid = 4'b0100; req_angle[95:64] = 32'h42B40000;
        #1 chk("t5_ready", 32'(req_ready), 32'h4);
        tick(); req_valid = '0;
        wait_resp(40, n);
        chk("t5_latency", n, 19);
        chk("t5_id",  32'(resp_id),  32'h2);
        chk("t5_sin", 32'(resp_sin), 32'h7FFF);
        chk("t5_cos", 32'(resp_cos), 32'h0000);
        tick();

        // ---------------- T6: core that never completes
        stub_never = 1'b1;
        req_valid = 4'b0010; req_angle[63:32] = 32'h00000000;
        #1 chk("t6_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = '0;
`ifdef CORDIC_TIMEOUT_EN
        wait_resp(200, n);
        chk("t6_to_latency", n, 67);
        chk("t6_to_err", 32'(resp_err), 32'h1);
        chk("t6_to_id",  32'(resp_id),  32'h1);
        chk("t6_to_sin", 32'(resp_sin), 32'h0);
        chk("t6_to_cos", 32'(resp_cos), 32'h0);
        tick();
`else
        seen = 0; drop = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (resp_valid) seen++;
            if (!busy) drop++;
        end
        chk("t6_hang_resp", seen, 0);
        chk("t6_hang_busy", drop, 0);
        rst = 1'b1; tick(); rst = 1'b0; tick();
`endif
        stub_never = 1'b0;
        req_valid = 4'b1000; req_angle[127:96] = 32'h42340000;
        #1 chk("t6_rec_ready", 32'(req_ready), 32'h8);
        tick(); req_valid = '0;
        wait_resp(40, n);
        chk("t6_rec_latency", n, 19);
        chk("t6_rec_err", 32'(resp_err), 32'h0);
        chk("t6_rec_sin", 32'(resp_sin), 32'h5A82);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
